// File: rtl/wash_cycle_ctrl.sv
// wash_cycle_ctrl: washing-machine cycle sequencer with mode/weight selection, pause and end buzzer
//
// Parameters (seconds; FILL/WASH/RINSE are scaled by the selected weight 1..3):
//   FILL_T, WASH_T, RINSE_T  per-weight-unit phase times
//   DRAIN_T, SPIN_T          fixed phase times
//   BUZZ_T                   end-of-cycle buzzer time
// Ports:
//   clk, reset (async, active-low)
//   tick_1hz                 one-clk pulse per second
//   power_key, start_key, mode_key, weight_key   one-clk key pulses
//   door_closed / door_lock  only with WASH_DOOR_LOCK_EN defined
//   power, running           status
//   xi, piao, tuo            wash / rinse / spin motor enables
//   valve_in, valve_out      fill / drain valves
//   buzzer                   end-of-cycle alarm
//   mode[2:0], weight[1:0]   selection (0 when off)
//   phase_left, total_left   seconds remaining in phase / cycle
// Build option: WASH_DOOR_LOCK_EN adds the door interlock.
module wash_cycle_ctrl #(
    parameter int FILL_T  = 3,
    parameter int WASH_T  = 9,
    parameter int RINSE_T = 6,
    parameter int DRAIN_T = 3,
    parameter int SPIN_T  = 6,
    parameter int BUZZ_T  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       power_key,
    input  logic       start_key,
    input  logic       mode_key,
    input  logic       weight_key,
`ifdef WASH_DOOR_LOCK_EN
    input  logic       door_closed,
    output logic       door_lock,
`endif
    output logic       power,
    output logic       running,
    output logic       xi,
    output logic       piao,
    output logic       tuo,
    output logic       valve_in,
    output logic       valve_out,
    output logic       buzzer,
    output logic [2:0] mode,
    output logic [1:0] weight,
    output logic [7:0] phase_left,
    output logic [7:0] total_left
);
    typedef enum logic [3:0] {
        OFF, IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, DONE
    } state_t;

    state_t     state, state_n;
    logic       paused, paused_n;
    logic [2:0] mode_r, mode_n;
    logic [1:0] weight_r, weight_n;
    logic [7:0] phase_r, phase_n, total_r, total_n;
    logic       door_ok, in_phase;
    logic [7:0] fill_d, wash_d, rinse_d, total_d;
    state_t     first_ph, next_ph;

`ifdef WASH_DOOR_LOCK_EN
    assign door_ok   = door_closed;
    assign door_lock = in_phase;
`else
    assign door_ok = 1'b1;
`endif

    function automatic state_t seq_next(input state_t s, input logic [2:0] m);
        case (s)
            FILL_W:  seq_next = WASH;
            WASH:    seq_next = DRAIN_W;
            DRAIN_W: seq_next = (m == 3'd1) ? DONE : FILL_R;
            FILL_R:  seq_next = RINSE;
            RINSE:   seq_next = DRAIN_R;
            DRAIN_R: seq_next = (m == 3'd2 || m == 3'd4) ? DONE : SPIN;
            default: seq_next = DONE;
        endcase
    endfunction

    function automatic logic [7:0] dur(input state_t s, input logic [7:0] f,
                                       input logic [7:0] w, input logic [7:0] r);
        case (s)
            FILL_W, FILL_R:   dur = f;
            WASH:             dur = w;
            RINSE:            dur = r;
            DRAIN_W, DRAIN_R: dur = 8'(DRAIN_T);
            SPIN:             dur = 8'(SPIN_T);
            DONE:             dur = 8'(BUZZ_T);
            default:          dur = 8'd0;
        endcase
    endfunction

    assign fill_d  = 8'(FILL_T) * {6'd0, weight_r};
    assign wash_d  = 8'(WASH_T) * {6'd0, weight_r};
    assign rinse_d = 8'(RINSE_T) * {6'd0, weight_r};
    // Cycle total is built from the three optional segments each mode enables.
    assign total_d = ((mode_r <= 3'd2) ? fill_d + wash_d + 8'(DRAIN_T) : 8'd0)
                   + ((mode_r <= 3'd4 && mode_r != 3'd1) ? fill_d + rinse_d + 8'(DRAIN_T) : 8'd0)
                   + ((mode_r == 3'd0 || mode_r == 3'd3 || mode_r == 3'd5) ? 8'(SPIN_T) : 8'd0);
    assign first_ph = (mode_r <= 3'd2) ? FILL_W : (mode_r <= 3'd4) ? FILL_R : SPIN;
    assign next_ph  = seq_next(state, mode_r);
    assign in_phase = (state >= FILL_W) && (state <= SPIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= OFF;
            paused   <= 1'b0;
            mode_r   <= 3'd0;
            weight_r <= 2'd1;
            phase_r  <= 8'd0;
            total_r  <= 8'd0;
        end else begin
            state    <= state_n;
            paused   <= paused_n;
            mode_r   <= mode_n;
            weight_r <= weight_n;
            phase_r  <= phase_n;
            total_r  <= total_n;
        end
    end

    always_comb begin
        state_n  = state;
        paused_n = paused;
        mode_n   = mode_r;
        weight_n = weight_r;
        phase_n  = phase_r;
        total_n  = total_r;
        if (power_key) begin
            state_n  = (state == OFF) ? IDLE : OFF;
            paused_n = 1'b0;
            mode_n   = 3'd0;
            weight_n = 2'd1;
            phase_n  = 8'd0;
            total_n  = 8'd0;
        end else if (state == IDLE) begin
            // A start pulse outranks the selection keys even when the door blocks it.
            if (start_key) begin
                if (door_ok) begin
                    state_n = first_ph;
                    phase_n = dur(first_ph, fill_d, wash_d, rinse_d);
                    total_n = total_d;
                end
            end else if (mode_key)
                mode_n = (mode_r == 3'd5) ? 3'd0 : mode_r + 3'd1;
            else if (weight_key)
                weight_n = (weight_r == 2'd3) ? 2'd1 : weight_r + 2'd1;
        end else if (state == DONE) begin
            if (tick_1hz) begin
                phase_n = phase_r - 8'd1;
                state_n = (phase_r == 8'd1) ? IDLE : DONE;
            end
        end else if (in_phase) begin
            // A start pulse consumes any coincident tick, so pausing never loses or gains a second.
            if (start_key) begin
                if (paused ? door_ok : 1'b1)
                    paused_n = !paused;
            end else if (tick_1hz && !paused) begin
                total_n = total_r - 8'd1;
                state_n = (phase_r == 8'd1) ? next_ph : state;
                phase_n = (phase_r == 8'd1) ? dur(next_ph, fill_d, wash_d, rinse_d) : phase_r - 8'd1;
            end
        end
    end

    assign power      = (state != OFF);
    assign running    = in_phase && !paused;
    assign valve_in   = !paused && (state == FILL_W || state == FILL_R);
    assign xi         = !paused && (state == WASH);
    assign piao       = !paused && (state == RINSE);
    assign valve_out  = !paused && (state == DRAIN_W || state == DRAIN_R || state == SPIN);
    assign tuo        = !paused && (state == SPIN);
    assign buzzer     = (state == DONE);
    assign mode       = power ? mode_r : 3'd0;
    assign weight     = power ? weight_r : 2'd0;
    assign phase_left = phase_r;
    assign total_left = total_r;
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// tb_wash_cycle_ctrl: directed self-checking bench for wash_cycle_ctrl
module tb_wash_cycle_ctrl;
    logic       clk, reset, tick_1hz, power_key, start_key, mode_key, weight_key;
    logic       power, running, xi, piao, tuo, valve_in, valve_out, buzzer;
    logic [2:0] mode;
    logic [1:0] weight;
    logic [7:0] phase_left, total_left;
    logic       door_closed, door_lock;
    int         errors = 0;
    int         checks = 0;

    wash_cycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .power_key  (power_key),
        .start_key  (start_key),
        .mode_key   (mode_key),
        .weight_key (weight_key),
`ifdef WASH_DOOR_LOCK_EN
        .door_closed(door_closed),
        .door_lock  (door_lock),
`endif
        .power      (power),
        .running    (running),
        .xi         (xi),
        .piao       (piao),
        .tuo        (tuo),
        .valve_in   (valve_in),
        .valve_out  (valve_out),
        .buzzer     (buzzer),
        .mode       (mode),
        .weight     (weight),
        .phase_left (phase_left),
        .total_left (total_left)
    );

`ifndef WASH_DOOR_LOCK_EN
    assign door_lock = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Actuators packed as {valve_in, valve_out, xi, piao, tuo, buzzer}.
    function automatic logic [5:0] act();
        return {valve_in, valve_out, xi, piao, tuo, buzzer};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given key pulses; called and returns on a falling edge.
    task automatic cyc(input logic p, input logic s, input logic m, input logic w, input logic t);
        power_key = p; start_key = s; mode_key = m; weight_key = w; tick_1hz = t;
        @(negedge clk);
        power_key = 0; start_key = 0; mode_key = 0; weight_key = 0; tick_1hz = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 0; tick_1hz = 0; power_key = 0; start_key = 0; mode_key = 0; weight_key = 0;
        door_closed = 1;
        #12;
        chk("reset_power", power, 0);
        chk("reset_act", act(), 0);
        chk("reset_mode", mode, 0);
        chk("reset_weight", weight, 0);
        chk("reset_phase", phase_left, 0);
        @(negedge clk);
        reset = 1;
        cyc(0, 0, 1, 0, 0);
        chk("off_ignores_keys", power, 0);

        cyc(1, 0, 0, 0, 0);
        chk("power_on", power, 1);
        chk("power_on_mode", mode, 0);
        chk("power_on_weight", weight, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
        chk("mode5", mode, 5);
        cyc(0, 1, 0, 0, 0);
        chk("spin_act", act(), 6'b010010);
        chk("spin_phase", phase_left, 6);
        chk("spin_total", total_left, 6);
        chk("spin_running", running, 1);
        chk("door_lock", door_lock, `ifdef WASH_DOOR_LOCK_EN 1 `else 0 `endif);
        ticks(5);
        chk("spin_phase_1", phase_left, 1);
        ticks(1);
        chk("done_act", act(), 6'b000001);
        chk("done_phase", phase_left, 3);
        chk("done_total", total_left, 0);
        chk("done_running", running, 0);
        cyc(0, 1, 1, 0, 0);
        chk("done_ignores_start", phase_left, 3);
        chk("done_ignores_mode", mode, 5);
        ticks(2);
        chk("done_buzz_last", buzzer, 1);
        ticks(1);
        chk("idle_after_done", act(), 0);
        chk("idle_phase", phase_left, 0);

        cyc(0, 0, 1, 0, 0);
        chk("mode_wrap", mode, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("weight2", weight, 2);
        cyc(0, 1, 0, 0, 0);
        chk("m1_total", total_left, 27);
        chk("m1_fill_phase", phase_left, 6);
        chk("m1_fill_act", act(), 6'b100000);
        ticks(5);
        chk("m1_fill_end", act(), 6'b100000);
        ticks(1);
        chk("m1_wash_act", act(), 6'b001000);
        chk("m1_wash_phase", phase_left, 18);
        chk("m1_wash_total", total_left, 21);
        ticks(18);
        chk("m1_drain_act", act(), 6'b010000);
        chk("m1_drain_phase", phase_left, 3);
        ticks(3);
        chk("m1_done", buzzer, 1);
        ticks(3);
        chk("m1_idle", buzzer, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("weight_wrap", weight, 1);

        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
        chk("mode0_again", mode, 0);
        cyc(0, 1, 0, 0, 0);
        chk("m0_total", total_left, 33);
        ticks(5);
        chk("m0_wash_phase", phase_left, 7);
        chk("m0_wash_total", total_left, 28);
        cyc(0, 1, 0, 0, 0);
        chk("pause_running", running, 0);
        chk("pause_act", act(), 0);
        ticks(10);
        chk("pause_phase_hold", phase_left, 7);
        chk("pause_total_hold", total_left, 28);
        cyc(0, 1, 0, 0, 0);
        chk("resume_running", running, 1);
        chk("resume_act", act(), 6'b001000);
        chk("resume_phase", phase_left, 7);
        cyc(0, 1, 0, 0, 1);
        chk("pause_eats_tick", phase_left, 7);
        chk("pause_eats_tick_run", running, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(7);
        chk("m0_drain_w", act(), 6'b010000);
        chk("m0_drain_w_total", total_left, 21);
        ticks(3);
        chk("m0_fill_r", act(), 6'b100000);
        ticks(3);
        chk("m0_rinse", act(), 6'b000100);
        chk("m0_rinse_phase", phase_left, 6);
        chk("m0_rinse_total", total_left, 15);

        cyc(1, 0, 0, 0, 0);
        chk("abort_power", power, 0);
        chk("abort_act", act(), 0);
        chk("abort_running", running, 0);
        chk("abort_total", total_left, 0);
        cyc(1, 0, 0, 0, 0);
        chk("repower", power, 1);
        chk("repower_mode", mode, 0);
        chk("repower_weight", weight, 1);

        cyc(0, 1, 1, 0, 0);
        chk("start_beats_mode", mode, 0);
        chk("start_beats_mode_total", total_left, 33);
        ticks(3);
        cyc(0, 0, 1, 0, 0);
        chk("wash_ignores_mode", mode, 0);
        chk("wash_phase", phase_left, 9);
        ticks(24);
        chk("m0_spin", act(), 6'b010010);
        chk("m0_spin_total", total_left, 6);
        #2 reset = 0;
        #1;
        chk("async_reset_power", power, 0);
        chk("async_reset_act", act(), 0);
        chk("async_reset_phase", phase_left, 0);
        @(negedge clk);
        reset = 1;
        cyc(0, 0, 0, 0, 1);
        chk("post_reset_act", act(), 0);
        chk("post_reset_power", power, 0);

`ifdef WASH_DOOR_LOCK_EN
        cyc(1, 0, 0, 0, 0);
        door_closed = 0;
        cyc(0, 1, 0, 0, 0);
        chk("door_open_start", running, 0);
        chk("door_open_phase", phase_left, 0);
        door_closed = 1;
        cyc(0, 1, 0, 0, 0);
        chk("door_closed_start", running, 1);
        chk("door_lock_on", door_lock, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
